// File: rtl/mult_seq_if.sv
// Handshake and data bundle for the sequential multiplier.
// The control side drives the master modport; the multiplier is the slave.
interface mult_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, sign handled by magnitudes.
// Optional MULT_SEQ_EARLY_TERM_EN exits RUN once the remaining multiplier bits are all zero.
module mult_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic       clk,
  input logic       rst,
  mult_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcnd_q, mcnd_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   a_mag, b_mag, addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_res;
  logic               last_iter;

  always_comb begin
    a_mag  = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag  = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    addend = mplr_q[0] ? mcnd_q : {WIDTH{1'b0}};
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  end

`ifdef MULT_SEQ_EARLY_TERM_EN
  localparam logic [CNT_W-1:0] WidthCnt = CNT_W'(WIDTH);
  // Skipped iterations would only shift in zeros, so a final shift restores alignment.
  always_comb begin
    last_iter = (cnt_q == LastCnt) || (mplr_q[WIDTH-1:1] == '0);
    acc_res   = acc_q >> (WidthCnt - cnt_q);
  end
`else
  always_comb begin
    last_iter = (cnt_q == LastCnt);
    acc_res   = acc_q;
  end
`endif

  always_comb begin
    state_d = state_q;
    mcnd_d  = mcnd_q;
    mplr_d  = mplr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mcnd_d  = a_mag;
          mplr_d  = b_mag;
          // Zero operand never yields a negated result.
          neg_d   = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) & (|bus.a) & (|bus.b);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d  = {sum, acc_q[WIDTH-1:1]};
        mplr_d = mplr_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        if (last_iter) state_d = StFin;
      end
      StFin: begin
        {hi_d, lo_d} = neg_q ? -acc_res : acc_res;
        done_d       = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mcnd_q  <= '0;
      mplr_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcnd_q  <= mcnd_d;
      mplr_q  <= mplr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed vector bench for mult_seq at WIDTH=32, with hand sequences for
// reset abort, ignored START while busy and back-to-back issue.
module tb_mult_seq;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mult_seq_if #(.WIDTH(W)) bus ();

  mult_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected cycles from the capture edge to DONE, capture edge included.
  function automatic int exp_lat(input logic [W-1:0] b, input logic s);
`ifdef MULT_SEQ_EARLY_TERM_EN
    logic [W-1:0] mag;
    int len;
    mag = (s && b[W-1]) ? -b : b;
    len = 0;
    for (int i = 0; i < W; i++) if (mag[i]) len = i + 1;
    return ((len < 1) ? 1 : len) + 2;
`else
    return W + 2;
`endif
  endfunction

  // Presents operands, steps through the capture edge, then scrambles inputs.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bus.start     = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.is_signed = s;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.is_signed = 1'($urandom);
  endtask

  task automatic wait_done(inout int n);
    while (!bus.done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  vec_t vecs[10];
  int   n;
  logic seen_done;
  logic [W-1:0] prev_hi, prev_lo;

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{32'hFFFF_FFF9, 32'h0000_0006, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
    vecs[2] = '{32'hFFFF_FFF9, 32'h0000_0006, 1'b0, 32'h0000_0005, 32'hFFFF_FFD6};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000};
    vecs[4] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{32'h1234_5678, 32'h0000_0003, 1'b0, 32'h0000_0000, 32'h369D_0368};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001};
    vecs[7] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[8] = '{32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0000_0001, 32'h0000_0000};
    vecs[9] = '{32'h0000_0005, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1};

    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.is_signed = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_busy", W'(bus.busy), '0);
    check("reset_done", W'(bus.done), '0);
    check("reset_hi", bus.hi, '0);
    check("reset_lo", bus.lo, '0);

    // Abort at RUN iteration 10.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", W'(bus.busy), '0);
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen_done |= bus.done;
    end
    check("abort_no_done", W'(seen_done), '0);
    check("abort_hi", bus.hi, '0);
    check("abort_lo", bus.lo, '0);

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].s);
      n = 1;
      wait_done(n);
      check($sformatf("vec%0d_lat", i), W'(n), W'(exp_lat(vecs[i].b, vecs[i].s)));
      check($sformatf("vec%0d_hi", i), bus.hi, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), bus.lo, vecs[i].lo);
    end
    prev_hi = vecs[9].hi;
    prev_lo = vecs[9].lo;

    // START pulsed mid-RUN with other operands must be ignored; HI/LO hold meanwhile.
    issue(32'hFFFF_FFF9, 32'h0000_0006, 1'b1);
    n = 1;
    bus.start = 1'b1; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF; bus.is_signed = 1'b0;
    @(posedge clk);
    #1;
    n++;
    bus.start = 1'b0;
    check("run_hold_hi", bus.hi, prev_hi);
    check("run_hold_lo", bus.lo, prev_lo);
    check("run_busy", W'(bus.busy), 1);
    wait_done(n);
    check("ignore_lat", W'(n), W'(exp_lat(32'h0000_0006, 1'b1)));
    check("ignore_hi", bus.hi, 32'hFFFF_FFFF);
    check("ignore_lo", bus.lo, 32'hFFFF_FFD6);

    // Back-to-back issue in the DONE cycle.
    issue(32'h0000_0010, 32'h0000_0010, 1'b0);
    check("b2b_busy", W'(bus.busy), 1);
    check("b2b_done_low", W'(bus.done), '0);
    n = 1;
    wait_done(n);
    check("b2b_lat", W'(n), W'(exp_lat(32'h0000_0010, 1'b0)));
    check("b2b_hi", bus.hi, 32'h0000_0000);
    check("b2b_lo", bus.lo, 32'h0000_0100);
    @(posedge clk);
    #1;
    check("done_pulse", W'(bus.done), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
